// File: rtl/dma_pkg.sv
// rtl/dma_pkg.sv - shared FSM states and default widths for the ROM fetch path
package dma_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_ACCESS = 3'd2,
    ST_OUTPUT = 3'd3,
    ST_FINISH = 3'd4
  } state_t;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 8;

endpackage

// File: rtl/rom_fetcher.sv
// rtl/rom_fetcher.sv - walks a ROM address range, one chip-enable read per byte,
// and streams each fetched byte out over a valid/ready handshake
module rom_fetcher
  import dma_pkg::*;
#(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int LEN_W    = 16,
  parameter int WAIT_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [LEN_W-1:0]  length,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] rom_addr,
  output logic              rom_ce_n,
  input  logic [DATA_W-1:0] rom_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready
);

  localparam int CNT_W = $clog2(WAIT_CYC + 1);

  state_t             state;
  logic [ADDR_W-1:0]  next_addr;
  logic [LEN_W-1:0]   remaining;
  logic [CNT_W-1:0]   wait_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rom_addr  <= '0;
      rom_ce_n  <= 1'b1;
      out_data  <= '0;
      out_valid <= 1'b0;
      next_addr <= '0;
      remaining <= '0;
      wait_cnt  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            if (length != '0) begin
              // Address is driven on entry to SETUP so it is stable a full cycle before enable.
              rom_addr  <= start_addr;
              next_addr <= start_addr;
              remaining <= length;
              busy      <= 1'b1;
              state     <= ST_SETUP;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_SETUP: begin
          rom_ce_n <= 1'b0;
          wait_cnt <= CNT_W'(WAIT_CYC);
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (wait_cnt == CNT_W'(1)) begin
            out_data  <= rom_data;
            out_valid <= 1'b1;
            rom_ce_n  <= 1'b1;
            next_addr <= next_addr + ADDR_W'(1);
            remaining <= remaining - LEN_W'(1);
            state     <= ST_OUTPUT;
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end
        ST_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (remaining != '0) begin
              rom_addr <= next_addr;
              state    <= ST_SETUP;
            end else begin
              state <= ST_FINISH;
            end
          end
        end
        ST_FINISH: begin
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rom_fetcher.sv
// tb/tb_rom_fetcher.sv - scoreboard bench for rom_fetcher with a behavioural ROM on the bus
module tb_rom_fetcher;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_addr = '0;
  logic [15:0] length = '0;
  logic        busy, done, rom_ce_n, out_valid;
  logic [15:0] rom_addr;
  logic [7:0]  rom_data, out_data;
  logic        out_ready = 1'b1;

  rom_fetcher #(.ADDR_W(16), .DATA_W(8), .LEN_W(16), .WAIT_CYC(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .start_addr(start_addr), .length(length),
    .busy(busy), .done(done), .rom_addr(rom_addr), .rom_ce_n(rom_ce_n), .rom_data(rom_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_byte(input logic [15:0] a);
    case (a)
      16'h0000: return 8'h21;
      16'h0001: return 8'h55;
      16'h0002: return 8'hAA;
      16'h0003: return 8'h22;
      16'h0010: return 8'hC3;
      default:  return 8'h00;
    endcase
  endfunction

  // Deselected bus reads back a poison value, so sampling outside enable shows up as EE.
  assign rom_data = rom_ce_n ? 8'hEE : rom_byte(rom_addr);

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [7:0]  exp_q[$];
  logic [15:0] addr_q[$];
  int          done_exp = 0;

  int          low_cnt = 0;
  logic        prev_ce = 1'b1;
  logic        hold_pend = 1'b0;
  logic [7:0]  hold_data = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      low_cnt   = 0;
      prev_ce   = 1'b1;
      hold_pend = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_byte: got %0h expected none", out_data);
        end else begin
          check("out_data", out_data, exp_q.pop_front());
        end
      end
      if (done) begin
        check("done_expected", done_exp > 0, 1);
        if (done_exp > 0) done_exp--;
      end
      if (!rom_ce_n && prev_ce) begin
        if (addr_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL extra_access: got addr %0h expected none", rom_addr);
        end else begin
          check("rom_addr", rom_addr, addr_q.pop_front());
        end
      end
      if (!rom_ce_n) low_cnt++;
      else if (!prev_ce) begin
        check("ce_low_cycles", low_cnt, 2);
        low_cnt = 0;
      end
      if (hold_pend) begin
        check("hold_valid", out_valid, 1);
        check("hold_data", out_data, hold_data);
      end
      hold_pend = out_valid && !out_ready;
      hold_data = out_data;
      prev_ce   = rom_ce_n;
    end
  end

  task automatic pulse_start(input logic [15:0] a, input logic [15:0] n);
    @(negedge clk);
    start = 1'b1;
    start_addr = a;
    length = n;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (done) begin
        seen = 1;
        break;
      end
    end
    check(name, seen, 1);
  endtask

  task automatic expect_seq(input logic [15:0] a, input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] ai;
      ai = a + 16'(i);
      addr_q.push_back(ai);
      exp_q.push_back(rom_byte(ai));
    end
    done_exp++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ce_n", rom_ce_n, 1);
    check("rst_addr", rom_addr, 0);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    #2 rst_n = 1'b1;

    // 1: three bytes, ready high, with latency checks
    expect_seq(16'h0000, 3);
    pulse_start(16'h0000, 16'd3);
    check("t1_ce_setup", rom_ce_n, 1);
    check("t1_busy", busy, 1);
    @(negedge clk);
    check("t1_ce_low", rom_ce_n, 0);
    @(negedge clk);
    check("t1_valid_early", out_valid, 0);
    @(negedge clk);
    check("t1_valid_first", out_valid, 1);
    wait_done("t1_done");
    check("t1_busy_end", busy, 0);

    // 2: single byte held under backpressure
    expect_seq(16'h0010, 1);
    @(posedge clk) #1 out_ready = 1'b0;
    pulse_start(16'h0010, 16'd1);
    begin
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (out_valid) begin got = 1; break; end
      end
      check("t2_valid_seen", got, 1);
    end
    repeat (5) begin
      @(negedge clk);
      check("t2_ce_idle", rom_ce_n, 1);
      check("t2_data", out_data, 8'hC3);
    end
    @(posedge clk) #1 out_ready = 1'b1;
    wait_done("t2_done");

    // 3: address wrap
    addr_q.push_back(16'hFFFF); exp_q.push_back(8'h00);
    addr_q.push_back(16'h0000); exp_q.push_back(8'h21);
    done_exp++;
    pulse_start(16'hFFFF, 16'd2);
    wait_done("t3_done");

    // 4: zero length
    done_exp++;
    pulse_start(16'h0005, 16'd0);
    check("t4_done_early", done, 0);
    check("t4_ce", rom_ce_n, 1);
    check("t4_valid", out_valid, 0);
    @(negedge clk);
    check("t4_done", done, 1);
    check("t4_ce2", rom_ce_n, 1);
    check("t4_valid2", out_valid, 0);

    // 5: start while busy is ignored
    expect_seq(16'h0001, 3);
    pulse_start(16'h0001, 16'd3);
    @(negedge clk);
    check("t5_busy", busy, 1);
    pulse_start(16'h0010, 16'd1);
    wait_done("t5_done");
    repeat (12) @(negedge clk);
    check("t5_no_extra", exp_q.size(), 0);

    // 6: reset during access
    addr_q.push_back(16'h0000);
    pulse_start(16'h0000, 16'd3);
    begin
      bit got = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk);
        if (!rom_ce_n) begin got = 1; break; end
      end
      check("t6_access_seen", got, 1);
    end
    #2 rst_n = 1'b0;
    #1;
    check("t6_ce_n", rom_ce_n, 1);
    check("t6_valid", out_valid, 0);
    check("t6_busy", busy, 0);
    check("t6_done", done, 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check("t6_no_done", done, 0);
      check("t6_ce_idle", rom_ce_n, 1);
    end
    expect_seq(16'h0000, 3);
    pulse_start(16'h0000, 16'd3);
    wait_done("t6_restart_done");

    repeat (10) @(negedge clk);
    check("end_bytes_left", exp_q.size(), 0);
    check("end_addrs_left", addr_q.size(), 0);
    check("end_done_left", done_exp, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
